// File: rtl/exception_unit.sv
// exception_unit: EX-stage exception controller.
// Classifies error events on the saturating exception instruction, queues
// their causes in a small FIFO, and for each queued cause drives a
// multi-cycle flush and then a valid/ack report to the handler.
// Per-cause and dropped-event counters saturate for debug.
module exception_unit #(
   parameter int DATA_W    = 8,
   parameter int OPC_W     = 3,
   parameter int REG_W     = 3,
   parameter int EXC_OPC   = 1,
   parameter int EXC_RD    = 0,
   parameter int EXC_RS    = 3,
   parameter int FLUSH_CYC = 2,
   parameter int Q_DEPTH   = 4,
   parameter int CNT_W     = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                ex_valid,
   input  logic [OPC_W-1:0]                    opcode,
   input  logic [REG_W-1:0]                    rs,
   input  logic [REG_W-1:0]                    rd,
   input  logic [DATA_W-1:0]                   rs_val,
   input  logic                                exp_error,
   input  logic                                exc_ack,
   output logic                                flush,
   output logic                                exc_valid,
   output logic [1:0]                          exc_cause,
   output logic signed [2*DATA_W-1:0]          exc_sat_val,
   output logic [$clog2(Q_DEPTH):0]            q_count,
   output logic [CNT_W-1:0]                    cnt_pos,
   output logic [CNT_W-1:0]                    cnt_neg,
   output logic [CNT_W-1:0]                    cnt_ill,
   output logic [CNT_W-1:0]                    drop_cnt
);

   localparam int PTR_W = $clog2(Q_DEPTH);
   localparam int QC_W  = PTR_W + 1;
   localparam int SAT_W = 2 * DATA_W;

   localparam logic [OPC_W-1:0] EXC_OPC_L  = OPC_W'(EXC_OPC);
   localparam logic [REG_W-1:0] EXC_RD_L   = REG_W'(EXC_RD);
   localparam logic [REG_W-1:0] EXC_RS_L   = REG_W'(EXC_RS);
   localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYC - 1);
   localparam logic [QC_W-1:0]  Q_FULL     = QC_W'(Q_DEPTH);

   localparam logic [1:0] C_NONE = 2'b00;
   localparam logic [1:0] C_POS  = 2'b01;
   localparam logic [1:0] C_NEG  = 2'b10;
   localparam logic [1:0] C_ILL  = 2'b11;

   typedef enum logic [1:0] {IDLE, FLUSH, REPORT} state_t;

   // Cause of an event: only the exact operand pattern saturates.
   function automatic logic [1:0] classify(input logic [OPC_W-1:0]  op,
                                           input logic [REG_W-1:0]  s,
                                           input logic [REG_W-1:0]  d,
                                           input logic [DATA_W-1:0] v);
      logic match;
      match = (op == EXC_OPC_L) && (d == EXC_RD_L) && (s == EXC_RS_L);
      if (match && (v == '0))
         return C_POS;
      else if (match && (v == DATA_W'(1)))
         return C_NEG;
      return C_ILL;
   endfunction

   // Saturation value shown to the handler for a given cause.
   function automatic logic signed [SAT_W-1:0] sat_value(input logic [1:0] c);
      case (c)
         C_POS:   return {1'b0, {(SAT_W-1){1'b1}}};
         C_NEG:   return {1'b1, {(SAT_W-1){1'b0}}};
         default: return '0;
      endcase
   endfunction

   // Counter increment that sticks at all ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
      if (en && (v != '1))
         return v + CNT_W'(1);
      return v;
   endfunction

   state_t            state;
   logic [3:0]        fl_cnt;

   logic [1:0]        q_mem [Q_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [QC_W-1:0]   q_cnt;
   logic              q_full;
   logic              q_empty;
   logic              push;
   logic              pop;

   logic              vld_p0;
   logic [1:0]        cause_p0;

   // ---- stage p0: event detection and classification in the EX cycle ----
   assign vld_p0   = ex_valid & exp_error;
   assign cause_p0 = classify(opcode, rs, rd, rs_val);

   assign q_full  = (q_cnt == Q_FULL);
   assign q_empty = (q_cnt == '0);
   assign pop     = exc_valid & exc_ack;
   assign push    = vld_p0 & (~q_full | pop);

   // Cause storage; contents are meaningless until the pointers say otherwise.
   always_ff @(posedge clk) begin
      if (push)
         q_mem[wr_ptr] <= cause_p0;
   end

   // FIFO pointers and occupancy; a pop frees a slot for a same-cycle push.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         q_cnt  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   q_cnt <= q_cnt + QC_W'(1);
            2'b01:   q_cnt <= q_cnt - QC_W'(1);
            default: q_cnt <= q_cnt;
         endcase
      end
   end

   // Debug counters: every event counts by cause, lost events count as drops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_pos  <= '0;
         cnt_neg  <= '0;
         cnt_ill  <= '0;
         drop_cnt <= '0;
      end else begin
         cnt_pos  <= sat_inc(cnt_pos,  vld_p0 && (cause_p0 == C_POS));
         cnt_neg  <= sat_inc(cnt_neg,  vld_p0 && (cause_p0 == C_NEG));
         cnt_ill  <= sat_inc(cnt_ill,  vld_p0 && (cause_p0 == C_ILL));
         drop_cnt <= sat_inc(drop_cnt, vld_p0 && !push);
      end
   end

   // ---- stage p1: flush/report sequencer on registered queue state ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         fl_cnt    <= '0;
         flush     <= 1'b0;
         exc_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!q_empty) begin
                  state  <= FLUSH;
                  fl_cnt <= FLUSH_LOAD;
                  flush  <= 1'b1;
               end
            end
            FLUSH: begin
               if (fl_cnt == '0) begin
                  state     <= REPORT;
                  flush     <= 1'b0;
                  exc_valid <= 1'b1;
               end else begin
                  fl_cnt <= fl_cnt - 4'd1;
               end
            end
            REPORT: begin
               if (exc_ack) begin
                  state     <= IDLE;
                  exc_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               flush     <= 1'b0;
               exc_valid <= 1'b0;
            end
         endcase
      end
   end

   assign exc_cause   = exc_valid ? q_mem[rd_ptr] : C_NONE;
   assign exc_sat_val = sat_value(exc_cause);
   assign q_count     = q_cnt;

endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit: table vectors, directed multi-cycle sequences and a
// randomized run against a queue-based reference model of exception_unit.
module tb_exception_unit;

   localparam int DATA_W    = 8;
   localparam int OPC_W     = 3;
   localparam int REG_W     = 3;
   localparam int FLUSH_CYC = 2;
   localparam int Q_DEPTH   = 4;
   localparam int CNT_W     = 8;
   localparam int SAT_W     = 2 * DATA_W;
   localparam int QC_W      = $clog2(Q_DEPTH) + 1;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;
   localparam int SAT_POSV  = (1 << (SAT_W - 1)) - 1;
   localparam int SAT_NEGV  = (1 << (SAT_W - 1));

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ex_valid = 1'b0;
   logic [OPC_W-1:0]  opcode = '0;
   logic [REG_W-1:0]  rs = '0;
   logic [REG_W-1:0]  rd = '0;
   logic [DATA_W-1:0] rs_val = '0;
   logic              exp_error = 1'b0;
   logic              exc_ack = 1'b0;
   logic              flush;
   logic              exc_valid;
   logic [1:0]        exc_cause;
   logic [SAT_W-1:0]  exc_sat_val;
   logic [QC_W-1:0]   q_count;
   logic [CNT_W-1:0]  cnt_pos;
   logic [CNT_W-1:0]  cnt_neg;
   logic [CNT_W-1:0]  cnt_ill;
   logic [CNT_W-1:0]  drop_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   exception_unit #(
      .DATA_W(DATA_W), .OPC_W(OPC_W), .REG_W(REG_W), .EXC_OPC(1), .EXC_RD(0),
      .EXC_RS(3), .FLUSH_CYC(FLUSH_CYC), .Q_DEPTH(Q_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .opcode(opcode), .rs(rs),
      .rd(rd), .rs_val(rs_val), .exp_error(exp_error), .exc_ack(exc_ack),
      .flush(flush), .exc_valid(exc_valid), .exc_cause(exc_cause),
      .exc_sat_val(exc_sat_val), .q_count(q_count), .cnt_pos(cnt_pos),
      .cnt_neg(cnt_neg), .cnt_ill(cnt_ill), .drop_cnt(drop_cnt)
   );

   typedef struct {
      logic [OPC_W-1:0]  op;
      logic [REG_W-1:0]  s;
      logic [REG_W-1:0]  d;
      logic [DATA_W-1:0] v;
      logic              ev;
      logic              er;
      logic              exp_evt;
      logic [1:0]        exp_cause;
      int                exp_sat;
   } vec_t;

   vec_t vecs[10];

   // reference model state
   int mq[$];
   int m_busy;
   int m_pos, m_neg, m_ill, m_drop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      ex_valid = 1'b0; exp_error = 1'b0; opcode = '0; rs = '0; rd = '0; rs_val = '0;
   endtask

   task automatic set_ev(input logic [OPC_W-1:0] op, input logic [REG_W-1:0] s,
                         input logic [REG_W-1:0] d, input logic [DATA_W-1:0] v,
                         input logic ev, input logic er);
      opcode = op; rs = s; rd = d; rs_val = v; ex_valid = ev; exp_error = er;
   endtask

   task automatic set_cause(input int c);
      case (c)
         1:       set_ev(3'd1, 3'd3, 3'd0, 8'd0, 1'b1, 1'b1);
         2:       set_ev(3'd1, 3'd3, 3'd0, 8'd1, 1'b1, 1'b1);
         default: set_ev(3'd1, 3'd2, 3'd0, 8'd0, 1'b1, 1'b1);
      endcase
   endtask

   task automatic do_reset();
      rst_n = 1'b0; exc_ack = 1'b0; idle_in();
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic wait_valid();
      int k;
      k = 0;
      while (!exc_valid && k < 20) begin
         cyc();
         k++;
      end
      chk("wait_valid", 32'(exc_valid), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_flush"}, 32'(flush), 32'd0);
      chk({tag, "_valid"}, 32'(exc_valid), 32'd0);
      chk({tag, "_cause"}, 32'(exc_cause), 32'd0);
      chk({tag, "_sat"}, 32'(exc_sat_val), 32'd0);
      chk({tag, "_qcount"}, 32'(q_count), 32'd0);
      chk({tag, "_cnt_pos"}, 32'(cnt_pos), 32'd0);
      chk({tag, "_cnt_neg"}, 32'(cnt_neg), 32'd0);
      chk({tag, "_cnt_ill"}, 32'(cnt_ill), 32'd0);
      chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
   endtask

   function automatic int sat_of(input int c);
      if (c == 1) return SAT_POSV;
      if (c == 2) return SAT_NEGV;
      return 0;
   endfunction

   function automatic int bump(input int v);
      return (v < CNT_MAX) ? v + 1 : v;
   endfunction

   // one clock edge of the reference model, given this cycle's inputs
   task automatic model_edge();
      int  old_size;
      bit  valid_now;
      bit  evt;
      bit  match;
      int  c;
      if (!rst_n) begin
         mq.delete();
         m_busy = 0; m_pos = 0; m_neg = 0; m_ill = 0; m_drop = 0;
         return;
      end
      old_size  = mq.size();
      valid_now = (m_busy == FLUSH_CYC + 1);
      evt       = ex_valid && exp_error;
      match     = (opcode == 1) && (rd == 0) && (rs == 3);
      c         = (match && rs_val == 0) ? 1 : (match && rs_val == 1) ? 2 : 3;
      if (evt) begin
         if (c == 1) m_pos = bump(m_pos);
         else if (c == 2) m_neg = bump(m_neg);
         else m_ill = bump(m_ill);
      end
      if (valid_now && exc_ack) void'(mq.pop_front());
      if (evt) begin
         if (mq.size() < Q_DEPTH) mq.push_back(c);
         else m_drop = bump(m_drop);
      end
      if (m_busy == 0) m_busy = (old_size > 0) ? 1 : 0;
      else if (m_busy <= FLUSH_CYC) m_busy++;
      else if (exc_ack) m_busy = 0;
   endtask

   task automatic model_compare();
      bit e_valid;
      int e_cause;
      e_valid = (m_busy == FLUSH_CYC + 1);
      e_cause = (e_valid && mq.size() > 0) ? mq[0] : 0;
      chk("rnd_flush", 32'(flush), 32'((m_busy >= 1) && (m_busy <= FLUSH_CYC)));
      chk("rnd_valid", 32'(exc_valid), 32'(e_valid));
      chk("rnd_cause", 32'(exc_cause), 32'(e_cause));
      chk("rnd_sat", 32'(exc_sat_val), 32'(sat_of(e_cause)));
      chk("rnd_qcount", 32'(q_count), 32'(mq.size()));
      chk("rnd_cnt_pos", 32'(cnt_pos), 32'(m_pos));
      chk("rnd_cnt_neg", 32'(cnt_neg), 32'(m_neg));
      chk("rnd_cnt_ill", 32'(cnt_ill), 32'(m_ill));
      chk("rnd_drop", 32'(drop_cnt), 32'(m_drop));
   endtask

   initial begin
      int order_a[6];
      int order_b[4];
      bit seen;

      vecs[0] = '{3'd1, 3'd3, 3'd0, 8'd0,   1'b1, 1'b1, 1'b1, 2'b01, SAT_POSV};
      vecs[1] = '{3'd1, 3'd3, 3'd0, 8'd1,   1'b1, 1'b1, 1'b1, 2'b10, SAT_NEGV};
      vecs[2] = '{3'd1, 3'd3, 3'd0, 8'd2,   1'b1, 1'b1, 1'b1, 2'b11, 0};
      vecs[3] = '{3'd1, 3'd3, 3'd0, 8'hFF,  1'b1, 1'b1, 1'b1, 2'b11, 0};
      vecs[4] = '{3'd0, 3'd3, 3'd0, 8'd0,   1'b1, 1'b1, 1'b1, 2'b11, 0};
      vecs[5] = '{3'd1, 3'd3, 3'd1, 8'd0,   1'b1, 1'b1, 1'b1, 2'b11, 0};
      vecs[6] = '{3'd1, 3'd2, 3'd0, 8'd0,   1'b1, 1'b1, 1'b1, 2'b11, 0};
      vecs[7] = '{3'd1, 3'd3, 3'd0, 8'd0,   1'b0, 1'b1, 1'b0, 2'b00, 0};
      vecs[8] = '{3'd1, 3'd3, 3'd0, 8'd0,   1'b1, 1'b0, 1'b0, 2'b00, 0};
      vecs[9] = '{3'd7, 3'd7, 3'd7, 8'd1,   1'b1, 1'b1, 1'b1, 2'b11, 0};

      // reset state
      do_reset();
      chk_all_zero("reset");

      // table-driven single events: classification and report contents
      for (int i = 0; i < 10; i++) begin
         do_reset();
         set_ev(vecs[i].op, vecs[i].s, vecs[i].d, vecs[i].v, vecs[i].ev, vecs[i].er);
         cyc();
         idle_in();
         chk($sformatf("vec%0d_qcount", i), 32'(q_count), 32'(vecs[i].exp_evt));
         cyc(); cyc(); cyc();
         chk($sformatf("vec%0d_valid", i), 32'(exc_valid), 32'(vecs[i].exp_evt));
         chk($sformatf("vec%0d_cause", i), 32'(exc_cause), 32'(vecs[i].exp_cause));
         chk($sformatf("vec%0d_sat", i), 32'(exc_sat_val), 32'(vecs[i].exp_sat));
         chk($sformatf("vec%0d_cnt_pos", i), 32'(cnt_pos), 32'(vecs[i].exp_cause == 2'b01));
         chk($sformatf("vec%0d_cnt_neg", i), 32'(cnt_neg), 32'(vecs[i].exp_cause == 2'b10));
         chk($sformatf("vec%0d_cnt_ill", i), 32'(cnt_ill), 32'(vecs[i].exp_cause == 2'b11));
         exc_ack = 1'b1;
         cyc();
         exc_ack = 1'b0;
      end

      // single SAT_POS: exact cycle timing
      do_reset();
      set_cause(1);
      cyc();                                   // cycle 1
      idle_in();
      chk("pos_c1_qcount", 32'(q_count), 32'd1);
      chk("pos_c1_flush", 32'(flush), 32'd0);
      chk("pos_c1_cnt_pos", 32'(cnt_pos), 32'd1);
      cyc();                                   // cycle 2
      chk("pos_c2_flush", 32'(flush), 32'd1);
      cyc();                                   // cycle 3
      chk("pos_c3_flush", 32'(flush), 32'd1);
      chk("pos_c3_valid", 32'(exc_valid), 32'd0);
      cyc();                                   // cycle 4
      chk("pos_c4_flush", 32'(flush), 32'd0);
      chk("pos_c4_valid", 32'(exc_valid), 32'd1);
      chk("pos_c4_cause", 32'(exc_cause), 32'd1);
      chk("pos_c4_sat", 32'(exc_sat_val), 32'h7FFF);
      cyc();                                   // cycle 5
      chk("pos_c5_cause", 32'(exc_cause), 32'd1);
      cyc();                                   // cycle 6
      exc_ack = 1'b1;
      chk("pos_c6_valid", 32'(exc_valid), 32'd1);
      cyc();                                   // cycle 7
      exc_ack = 1'b0;
      chk("pos_c7_valid", 32'(exc_valid), 32'd0);
      chk("pos_c7_qcount", 32'(q_count), 32'd0);
      chk("pos_c7_cnt_pos", 32'(cnt_pos), 32'd1);

      // SAT_NEG with ack held high throughout
      do_reset();
      set_cause(2);
      exc_ack = 1'b1;
      cyc(); idle_in();                        // cycle 1
      cyc(); cyc();                            // cycle 3
      chk("neg_c3_valid", 32'(exc_valid), 32'd0);
      cyc();                                   // cycle 4
      chk("neg_c4_valid", 32'(exc_valid), 32'd1);
      chk("neg_c4_cause", 32'(exc_cause), 32'd2);
      chk("neg_c4_sat", 32'(exc_sat_val), 32'h8000);
      cyc();                                   // cycle 5
      exc_ack = 1'b0;
      chk("neg_c5_valid", 32'(exc_valid), 32'd0);
      chk("neg_c5_qcount", 32'(q_count), 32'd0);

      // non-matching event followed by exp_error without ex_valid
      do_reset();
      set_cause(3);
      cyc();
      set_ev(3'd1, 3'd3, 3'd0, 8'd0, 1'b0, 1'b1);
      cyc();
      idle_in();
      chk("ill_qcount", 32'(q_count), 32'd1);
      cyc(); cyc();                            // cycle 4
      chk("ill_cause", 32'(exc_cause), 32'd3);
      chk("ill_sat", 32'(exc_sat_val), 32'd0);
      exc_ack = 1'b1;
      cyc();
      exc_ack = 1'b0;
      chk("ill_cnt_ill", 32'(cnt_ill), 32'd1);
      chk("ill_cnt_pos", 32'(cnt_pos), 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         if (exc_valid || flush) seen = 1'b1;
      end
      chk("ill_no_second_report", 32'(seen), 32'd0);

      // six events without ack, then push+pop on a full FIFO, then drain
      order_a = '{1, 2, 3, 1, 2, 3};
      do_reset();
      for (int k = 0; k < 6; k++) begin
         set_cause(order_a[k]);
         cyc();
      end
      idle_in();
      chk("full_qcount", 32'(q_count), 32'd4);
      chk("full_drop", 32'(drop_cnt), 32'd2);
      chk("full_cnt_pos", 32'(cnt_pos), 32'd2);
      chk("full_cnt_ill", 32'(cnt_ill), 32'd2);
      wait_valid();
      chk("full_head_cause", 32'(exc_cause), 32'd1);
      set_cause(2);
      exc_ack = 1'b1;
      cyc();
      idle_in();
      exc_ack = 1'b0;
      chk("pushpop_qcount", 32'(q_count), 32'd4);
      chk("pushpop_drop", 32'(drop_cnt), 32'd2);
      chk("pushpop_cnt_neg", 32'(cnt_neg), 32'd3);
      order_b = '{2, 3, 1, 2};
      for (int k = 0; k < 4; k++) begin
         wait_valid();
         chk($sformatf("drain%0d_cause", k), 32'(exc_cause), 32'(order_b[k]));
         exc_ack = 1'b1;
         cyc();
         exc_ack = 1'b0;
      end
      chk("drain_qcount", 32'(q_count), 32'd0);

      // reset during FLUSH with three events queued
      do_reset();
      set_cause(1); cyc();
      set_cause(2); cyc();
      set_cause(3); cyc();                     // cycle 3
      idle_in();
      chk("rstfl_flush", 32'(flush), 32'd1);
      chk("rstfl_qcount", 32'(q_count), 32'd3);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk_all_zero("rstfl");
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         if (exc_valid || flush) seen = 1'b1;
      end
      chk("rstfl_no_report", 32'(seen), 32'd0);

      // counter saturation
      do_reset();
      for (int k = 0; k < 300; k++) begin
         set_cause(3);
         cyc();
      end
      idle_in();
      chk("sat_cnt_ill", 32'(cnt_ill), 32'(CNT_MAX));
      chk("sat_drop", 32'(drop_cnt), 32'(CNT_MAX));
      chk("sat_cnt_pos", 32'(cnt_pos), 32'd0);

      // randomized run against the reference model
      do_reset();
      mq.delete();
      m_busy = 0; m_pos = 0; m_neg = 0; m_ill = 0; m_drop = 0;
      for (int k = 0; k < 1500; k++) begin
         model_compare();
         rst_n     = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
         ex_valid  = ($urandom_range(0, 3) != 0);
         exp_error = ($urandom_range(0, 2) == 0);
         opcode    = ($urandom_range(0, 4) == 0) ? OPC_W'($urandom_range(0, 7)) : OPC_W'(1);
         rd        = ($urandom_range(0, 4) == 0) ? REG_W'($urandom_range(0, 7)) : REG_W'(0);
         rs        = ($urandom_range(0, 4) == 0) ? REG_W'($urandom_range(0, 7)) : REG_W'(3);
         rs_val    = DATA_W'($urandom_range(0, 2));
         exc_ack   = ($urandom_range(0, 2) == 0);
         model_edge();
         cyc();
      end
      model_compare();
      rst_n = 1'b1; exc_ack = 1'b0; idle_in();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/exception_unit.md
# exception_unit

Parametrised, sequential exception controller for the EX stage of the CPU pipeline. It classifies EX-stage error events on the saturating exception instruction into positive-saturate, negative-saturate or illegal causes, and queues them in a small FIFO. For each queued event it drives a multi-cycle pipeline flush, then presents the cause and its saturation value to the handler under a valid/ack handshake. Per-cause and dropped-event counters are kept for debug.

## Interface
- DATA_W, 8: register/operand width; saturation value is 2*DATA_W bits.
- OPC_W, 3: opcode width.
- REG_W, 3: register-index width.
- EXC_OPC, 1: opcode of the exception-capable instruction.
- EXC_RD, 0: required rd index for a saturate event.
- EXC_RS, 3: required rs index for a saturate event.
- FLUSH_CYC, 2: flush pulse length in cycles; legal range 1..15.
- Q_DEPTH, 4: event FIFO depth; power of two, at least 2.
- CNT_W, 8: width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ex_valid  in  1  EX-stage instruction valid this cycle.
- opcode  in  OPC_W  EX-stage opcode.
- rs  in  REG_W  EX-stage source index.
- rd  in  REG_W  EX-stage destination index.
- rs_val  in  DATA_W  value of rs.
- exp_error  in  1  EX-stage error flag.
- exc_ack  in  1  handler accepts the presented exception.
- flush  out  1  pipeline flush request.
- exc_valid  out  1  exception presented to the handler.
- exc_cause  out  2  00 none, 01 SAT_POS, 10 SAT_NEG, 11 ILLEGAL.
- exc_sat_val  out  2*DATA_W  saturation result for the presented cause.
- q_count  out  $clog2(Q_DEPTH)+1  FIFO occupancy.
- cnt_pos, cnt_neg, cnt_ill  out  CNT_W  per-cause detection counters.
- drop_cnt  out  CNT_W  events lost because the FIFO was full.

## Operation
- Event: a cycle with ex_valid=1 and exp_error=1. No other cycle produces an event.
- Classification, applied to an event:
  - opcode==EXC_OPC, rd==EXC_RD, rs==EXC_RS and rs_val==0 gives SAT_POS; exc_sat_val = {1'b0, all ones}, e.g. 0x7FFF at DATA_W=8.
  - Same operand match with rs_val==1 gives SAT_NEG; exc_sat_val = {1'b1, all zeros}, e.g. 0x8000 at DATA_W=8.
  - Any other event gives ILLEGAL; exc_sat_val = 0.
- The FIFO stores the cause only; exc_sat_val is decoded from the head cause.
- Push: an event pushes its cause into the FIFO.
  - If the FIFO is full and no pop happens in the same cycle, the event is dropped and drop_cnt increments.
  - Push and pop in the same cycle on a full FIFO: the pop frees a slot and the push is accepted.
- Counters: cnt_pos, cnt_neg and cnt_ill increment on every detected event, dropped or not. All four counters saturate at 2^CNT_W-1.
- FSM, with states IDLE, FLUSH and REPORT:
  - IDLE: when the FIFO is non-empty, go to FLUSH and load the flush counter with FLUSH_CYC-1.
  - FLUSH: flush=1. Decrement the counter; when it is 0, go to REPORT.
  - REPORT: exc_valid=1, exc_cause = FIFO head. On exc_ack=1, pop and go to IDLE.
- Outside REPORT, exc_valid=0, exc_cause=00 and exc_sat_val=0.
- exc_ack is ignored outside REPORT.
- Reset values: state IDLE, FIFO empty, q_count=0, all counters 0, flush=0, exc_valid=0, exc_cause=00, exc_sat_val=0. Reset in any state discards queued events.

## Timing
- flush and exc_valid are decoded from registered state only; there is no combinational path from inputs to them.
- Event sampled at the edge ending cycle 0:
  - q_count=1 in cycle 1.
  - FSM still IDLE in cycle 1.
  - flush=1 in cycles 2 .. 1+FLUSH_CYC.
  - exc_valid=1 from cycle 2+FLUSH_CYC.
- Counters update at the same edge that samples the event.
- Handshake:
  - exc_cause and exc_sat_val stay stable while exc_valid=1 and exc_ack=0.
  - After ack, the next cycle is always IDLE with exc_valid=0.
  - A remaining queued event starts a new flush one cycle after that.
- Minimum spacing between two reports: FLUSH_CYC+2 cycles.
- Reset has priority over every concurrent event, push or ack in the same cycle.

## Test plan
- Single SAT_POS (opcode=1, rd=0, rs=3, rs_val=0, exp_error=1, defaults):
  - flush high in cycles 2-3.
  - exc_valid from cycle 4 with cause 01 and exc_sat_val=0x7FFF.
  - exc_ack in cycle 6 gives exc_valid=0 in cycle 7; cnt_pos=1.
- SAT_NEG with ack held high: cause 10 and exc_sat_val=0x8000 present for exactly one cycle (cycle 4); q_count returns to 0.
- Non-matching event (rs=2, or rs_val=5), plus a cycle with exp_error=1 and ex_valid=0:
  - the first reports cause 11 with exc_sat_val=0; the second produces no event.
  - cnt_ill=1.
- Six consecutive events with no ack:
  - q_count saturates at 4 and drop_cnt=2.
  - acking four times reports causes in arrival order.
- Simultaneous push and ack-pop with FIFO full: q_count stays 4 and drop_cnt is unchanged.
- rst_n low for one cycle while in FLUSH with 3 events queued: all outputs and counters read 0 the next cycle, and no report follows.
